// File: rtl/regfile_wb_queue_if.sv
// Write-back queue port bundle: ALU/LSU result handshakes, the register file
// write port, decode forwarding lookups and the occupancy count.
interface regfile_wb_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            lsu_valid;
  logic            lsu_ready;
  logic [4:0]      lsu_rd_src;
  logic [XLEN-1:0] lsu_data;
  logic            alu_valid;
  logic            alu_ready;
  logic [4:0]      alu_rd_src;
  logic [XLEN-1:0] alu_data;
  logic            reg_we;
  logic [4:0]      rd_src;
  logic [XLEN-1:0] rd;
  logic [4:0]      rs1_src;
  logic [4:0]      rs2_src;
  logic            rs1_fwd_hit;
  logic [XLEN-1:0] rs1_fwd;
  logic            rs2_fwd_hit;
  logic [XLEN-1:0] rs2_fwd;
  logic [CW-1:0]   count;

  // Producer/decode side
  modport master (
    output lsu_valid, lsu_rd_src, lsu_data, alu_valid, alu_rd_src, alu_data,
           rs1_src, rs2_src,
    input  lsu_ready, alu_ready, reg_we, rd_src, rd,
           rs1_fwd_hit, rs1_fwd, rs2_fwd_hit, rs2_fwd, count
  );

  // Queue side
  modport slave (
    input  lsu_valid, lsu_rd_src, lsu_data, alu_valid, alu_rd_src, alu_data,
           rs1_src, rs2_src,
    output lsu_ready, alu_ready, reg_we, rd_src, rd,
           rs1_fwd_hit, rs1_fwd, rs2_fwd_hit, rs2_fwd, count
  );
endinterface

// File: rtl/regfile_wb_queue.sv
// In-order write-back queue for the RV32I register file. LSU and ALU results
// are enqueued (LSU older when both arrive together), one entry retires per
// cycle onto the regfile write port, and decode can look up the youngest
// pending value for two source registers.
module regfile_wb_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic              clk,
  input  logic              rst,
  regfile_wb_queue_if.slave wb
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int NRP = 2;  // decode read ports

  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] TWO  = CW'(2);

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } ent_t;

  ent_t          mem [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;

  logic [CW-1:0] free;
  logic          lsu_acc, alu_acc, lsu_enq, alu_enq, pop;
  logic [PW-1:0] alu_slot;

  // Space is judged on registered occupancy only; a same-cycle pop does not help.
  always_comb begin
    free         = FULL - count;
    wb.lsu_ready = !rst && (free >= ONE);
    wb.alu_ready = !rst && ((free >= TWO) || (free == ONE && !wb.lsu_valid));
    lsu_acc      = wb.lsu_valid && wb.lsu_ready;
    alu_acc      = wb.alu_valid && wb.alu_ready;
    // x0 results finish the handshake but never occupy a slot
    lsu_enq      = lsu_acc && (wb.lsu_rd_src != 5'd0);
    alu_enq      = alu_acc && (wb.alu_rd_src != 5'd0);
    pop          = (count != '0);
    alu_slot     = tail + PW'(lsu_enq);
  end

  // Head entry drives the regfile write port directly from state.
  always_comb begin
    wb.reg_we = pop;
    wb.rd_src = mem[head].rd;
    wb.rd     = mem[head].data;
    wb.count  = count;
  end

  // Pointer and occupancy update; reset discards everything still queued.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(pop);
      tail  <= tail + PW'(lsu_enq) + PW'(alu_enq);
      count <= count + CW'(lsu_enq) + CW'(alu_enq) - CW'(pop);
    end
  end

  // Entry storage, not reset; LSU takes the tail slot, ALU the one after it.
  always_ff @(posedge clk) begin
    if (lsu_enq) mem[tail]     <= '{rd: wb.lsu_rd_src, data: wb.lsu_data};
    if (alu_enq) mem[alu_slot] <= '{rd: wb.alu_rd_src, data: wb.alu_data};
  end

  logic [NRP-1:0][4:0]      rs_src;
  logic [NRP-1:0]           fwd_hit;
  logic [NRP-1:0][XLEN-1:0] fwd_data;

  assign rs_src[0] = wb.rs1_src;
  assign rs_src[1] = wb.rs2_src;

  generate
    for (genvar p = 0; p < NRP; p++) begin : g_fwd
      // Walk occupied entries oldest to youngest so the youngest match wins.
      always_comb begin
        fwd_hit[p]  = 1'b0;
        fwd_data[p] = '0;
        for (int k = 0; k < DEPTH; k++) begin
          if ((CW'(k) < count) && (rs_src[p] != 5'd0) &&
              (mem[head + PW'(k)].rd == rs_src[p])) begin
            fwd_hit[p]  = 1'b1;
            fwd_data[p] = mem[head + PW'(k)].data;
          end
        end
      end
    end
  endgenerate

  assign wb.rs1_fwd_hit = fwd_hit[0];
  assign wb.rs1_fwd     = fwd_data[0];
  assign wb.rs2_fwd_hit = fwd_hit[1];
  assign wb.rs2_fwd     = fwd_data[1];
endmodule

// File: tb/tb_regfile_wb_queue.sv
// Bench for regfile_wb_queue: directed scenarios plus random traffic, every
// cycle compared against a queue-based reference model.
module tb_regfile_wb_queue;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_wb_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) wb ();

  regfile_wb_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (wb.slave)
  );

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  ent_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle's inputs at the falling edge and let combinational outputs settle.
  task automatic drive(input logic r,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                       input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic [4:0] s1, input logic [4:0] s2);
    @(negedge clk);
    rst           = r;
    wb.lsu_valid  = lv;
    wb.lsu_rd_src = lrd;
    wb.lsu_data   = ld;
    wb.alu_valid  = av;
    wb.alu_rd_src = ard;
    wb.alu_data   = ad;
    wb.rs1_src    = s1;
    wb.rs2_src    = s2;
    #1;
  endtask

  task automatic idle(input logic [4:0] s1, input logic [4:0] s2);
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, s1, s2);
  endtask

  // Youngest queued value for a source register.
  task automatic lookup(input logic [4:0] s, output logic hit, output logic [31:0] d);
    hit = 1'b0;
    d   = 32'd0;
    if (s != 5'd0)
      for (int i = q.size() - 1; i >= 0; i--)
        if (q[i].r == s) begin
          hit = 1'b1;
          d   = q[i].d;
          break;
        end
  endtask

  // Compare every output with the model, then advance model and DUT one edge.
  task automatic tick();
    int          fr;
    logic        lr, ar, h;
    logic [31:0] d;
    ent_t        e;
    fr = DEPTH - q.size();
    lr = !rst && fr >= 1;
    ar = !rst && (fr >= 2 || (fr == 1 && !wb.lsu_valid));
    chk("lsu_ready", wb.lsu_ready, lr);
    chk("alu_ready", wb.alu_ready, ar);
    chk("count", wb.count, q.size());
    chk("reg_we", wb.reg_we, q.size() != 0);
    if (q.size() != 0) begin
      chk("rd_src", wb.rd_src, q[0].r);
      chk("rd", wb.rd, q[0].d);
    end
    lookup(wb.rs1_src, h, d);
    chk("rs1_hit", wb.rs1_fwd_hit, h);
    chk("rs1_fwd", wb.rs1_fwd, d);
    lookup(wb.rs2_src, h, d);
    chk("rs2_hit", wb.rs2_fwd_hit, h);
    chk("rs2_fwd", wb.rs2_fwd, d);
    if (rst) q.delete();
    else begin
      if (q.size() != 0) void'(q.pop_front());
      if (wb.lsu_valid && lr && wb.lsu_rd_src != 0) begin
        e.r = wb.lsu_rd_src; e.d = wb.lsu_data; q.push_back(e);
      end
      if (wb.alu_valid && ar && wb.alu_rd_src != 0) begin
        e.r = wb.alu_rd_src; e.d = wb.alu_data; q.push_back(e);
      end
    end
    @(posedge clk);
  endtask

  initial begin
    wb.lsu_valid = 0; wb.lsu_rd_src = 0; wb.lsu_data = 0;
    wb.alu_valid = 0; wb.alu_rd_src = 0; wb.alu_data = 0;
    wb.rs1_src = 0; wb.rs2_src = 0;

    // 1) two reset cycles, then idle
    repeat (2) begin
      drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
      chk("rst_lsu_ready", wb.lsu_ready, 1'b0);
      tick();
    end
    idle(5'd5, 5'd3);
    chk("t1_reg_we", wb.reg_we, 1'b0);
    chk("t1_count", wb.count, 0);
    chk("t1_ready", {wb.lsu_ready, wb.alu_ready}, 2'b11);
    chk("t1_hit", {wb.rs1_fwd_hit, wb.rs2_fwd_hit}, 2'b00);
    tick();

    // 2) lone ALU write retires the next cycle
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234, 5'd5, 5'd0);
    tick();
    idle(5'd5, 5'd0);
    chk("t2_we", wb.reg_we, 1'b1);
    chk("t2_rd_src", wb.rd_src, 5);
    chk("t2_rd", wb.rd, 32'h1234);
    chk("t2_fwd_head", wb.rs1_fwd, 32'h1234);
    tick();
    idle(5'd0, 5'd0);
    chk("t2_count", wb.count, 0);
    tick();

    // 3) same-cycle LSU/ALU to x3: ALU is younger
    drive(1'b0, 1'b1, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB, 5'd3, 5'd0);
    tick();
    idle(5'd3, 5'd3);
    chk("t3_count", wb.count, 2);
    chk("t3_fwd", wb.rs1_fwd, 32'hBB);
    chk("t3_first", wb.rd, 32'hAA);
    tick();
    idle(5'd3, 5'd0);
    chk("t3_second", wb.rd, 32'hBB);
    tick();
    idle(5'd0, 5'd0);
    tick();

    // 4) reach DEPTH-1 under back-to-back dual accepts, then contend
    drive(1'b0, 1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 5'd0, 5'd0);
    tick();
    drive(1'b0, 1'b1, 5'd4, 32'h44, 1'b1, 5'd6, 32'h66, 5'd6, 5'd4);
    tick();
    drive(1'b0, 1'b1, 5'd7, 32'h77, 1'b1, 5'd8, 32'h88, 5'd8, 5'd7);
    chk("t4_count", wb.count, DEPTH - 1);
    chk("t4_lsu_ready", wb.lsu_ready, 1'b1);
    chk("t4_alu_ready", wb.alu_ready, 1'b0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'h88, 5'd8, 5'd7);
    chk("t4_alu_free", wb.alu_ready, 1'b1);
    chk("t4_no_fwd", wb.rs1_fwd_hit, 1'b0);
    tick();
    repeat (5) begin idle(5'd8, 5'd0); tick(); end

    // 5) x0 write is dropped
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF, 5'd0, 5'd0);
    chk("t5_ready", wb.alu_ready, 1'b1);
    chk("t5_hit", wb.rs1_fwd_hit, 1'b0);
    tick();
    idle(5'd0, 5'd0);
    chk("t5_count", wb.count, 0);
    chk("t5_we", wb.reg_we, 1'b0);
    tick();

    // 6) reset with three entries pending
    drive(1'b0, 1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'hA0, 5'd0, 5'd0);
    tick();
    drive(1'b0, 1'b1, 5'd11, 32'hB0, 1'b1, 5'd12, 32'hC0, 5'd0, 5'd0);
    tick();
    drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd10, 5'd12);
    chk("t6_pending", wb.count, 3);
    tick();
    idle(5'd10, 5'd12);
    chk("t6_we", wb.reg_we, 1'b0);
    chk("t6_count", wb.count, 0);
    chk("t6_hit", {wb.rs1_fwd_hit, wb.rs2_fwd_hit}, 2'b00);
    tick();
    repeat (3) begin idle(5'd10, 5'd11); tick(); end

    // random traffic over a small register window to exercise forwarding
    for (int n = 0; n < 400; n++) begin
      drive(($urandom % 60) == 0,
            ($urandom % 3) != 0, 5'($urandom % 8), $urandom,
            ($urandom % 3) != 0, 5'($urandom % 8), $urandom,
            5'($urandom % 8), 5'($urandom % 8));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
